// File: rtl/evt_state_update_engine_if.sv
// Bundle of update-event, state-memory, spike and status signals for
// evt_state_update_engine. The master modport is the engine side.
// The slave modport is the sequencer / memory / spike-consumer side.
interface evt_state_update_engine_if #(
  parameter int unsigned NEURONS_ADDR_WIDTH = 12,
  parameter int unsigned STATE_DATA_WIDTH   = 16
);
  logic                          req_valid_i;
  logic                          req_ready_o;
  logic [NEURONS_ADDR_WIDTH-1:0] req_addr_i;
  logic [STATE_DATA_WIDTH-1:0]   req_weight_i;
  logic [STATE_DATA_WIDTH-1:0]   threshold_i;
  logic [STATE_DATA_WIDTH-1:0]   reset_val_i;
  logic [STATE_DATA_WIDTH-1:0]   leak_i;
  logic                          rd_en_o;
  logic [NEURONS_ADDR_WIDTH-1:0] rd_addr_o;
  logic [STATE_DATA_WIDTH-1:0]   rd_data_i;
  logic                          wr_en_o;
  logic [NEURONS_ADDR_WIDTH-1:0] wr_addr_o;
  logic [STATE_DATA_WIDTH-1:0]   wr_data_o;
  logic                          spike_valid_o;
  logic                          spike_ready_i;
  logic [NEURONS_ADDR_WIDTH-1:0] spike_addr_o;
  logic                          busy_o;

  modport master (
    input  req_valid_i, req_addr_i, req_weight_i, threshold_i, reset_val_i,
           leak_i, rd_data_i, spike_ready_i,
    output req_ready_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
           spike_valid_o, spike_addr_o, busy_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_weight_i, threshold_i, reset_val_i,
           leak_i, rd_data_i, spike_ready_i,
    input  req_ready_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
           spike_valid_o, spike_addr_o, busy_o
  );
endinterface

// File: rtl/evt_state_update_engine.sv
// Neuron state update engine: 2-stage read-modify-write per synaptic event.
// Stage A issues the read, stage B integrates with saturation, compares
// against threshold, writes back and loads the spike slot on fire.
// Optional macro EVT_STATE_LEAK_EN subtracts leak_i on every update.
module evt_state_update_engine #(
  parameter int unsigned NEURONS_ADDR_WIDTH = 12,
  parameter int unsigned STATE_DATA_WIDTH   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  evt_state_update_engine_if.master   bus
);
  localparam int unsigned AW = NEURONS_ADDR_WIDTH;
  localparam int unsigned DW = STATE_DATA_WIDTH;
  localparam int unsigned SW = DW + 2;

  localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

  logic          r_b_valid;
  logic [AW-1:0] r_b_addr;
  logic [DW-1:0] r_b_weight;
  logic          r_spk_valid;
  logic [AW-1:0] r_spk_addr;

  logic                 w_ready;
  logic                 w_accept;
  logic signed [SW-1:0] w_sum_ext;
  logic signed [DW-1:0] w_sum_sat;
  logic                 w_fire;
  logic                 w_b_fire;

  // Stage B arithmetic: wide sum of state and weight (minus leak), one saturation
  always_comb begin
    w_sum_ext = $signed({{2{bus.rd_data_i[DW-1]}}, bus.rd_data_i})
              + $signed({{2{r_b_weight[DW-1]}}, r_b_weight});
`ifdef EVT_STATE_LEAK_EN
    w_sum_ext = w_sum_ext - $signed({2'b00, bus.leak_i});
`endif
    if (w_sum_ext > SAT_MAX) begin
      w_sum_sat = SAT_MAX[DW-1:0];
    end else if (w_sum_ext < SAT_MIN) begin
      w_sum_sat = SAT_MIN[DW-1:0];
    end else begin
      w_sum_sat = w_sum_ext[DW-1:0];
    end
    w_fire   = (w_sum_sat >= $signed(bus.threshold_i));
    w_b_fire = r_b_valid & w_fire;
  end

  // Accept gating: no accept while a spike is pending or being produced, and
  // never a read to the bank parity of the in-flight write
  always_comb begin
    w_ready  = ~rst_i & ~r_spk_valid & ~w_b_fire
             & ~(r_b_valid & (bus.req_addr_i[0] == r_b_addr[0]));
    w_accept = bus.req_valid_i & w_ready;
  end

  // Output drive: stage A read request, stage B write-back, spike and status
  always_comb begin
    bus.req_ready_o   = w_ready;
    bus.rd_en_o       = w_accept;
    bus.rd_addr_o     = bus.req_addr_i;
    bus.wr_en_o       = r_b_valid;
    bus.wr_addr_o     = r_b_addr;
    bus.wr_data_o     = w_fire ? bus.reset_val_i : w_sum_sat;
    bus.spike_valid_o = r_spk_valid;
    bus.spike_addr_o  = r_spk_addr;
    bus.busy_o        = r_b_valid | r_spk_valid;
  end

  // Stage B registers: capture accepted event, valid for exactly one cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_b_valid  <= 1'b0;
      r_b_addr   <= '0;
      r_b_weight <= '0;
    end else begin
      r_b_valid <= w_accept;
      if (w_accept) begin
        r_b_addr   <= bus.req_addr_i;
        r_b_weight <= bus.req_weight_i;
      end
    end
  end

  // Spike slot: loaded by a firing stage B, held until consumed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_spk_valid <= 1'b0;
      r_spk_addr  <= '0;
    end else begin
      // Load and consume never coincide: accept is blocked while the slot is full
      if (w_b_fire) begin
        r_spk_valid <= 1'b1;
        r_spk_addr  <= r_b_addr;
      end else if (r_spk_valid & bus.spike_ready_i) begin
        r_spk_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_evt_state_update_engine.sv
// Self-checking bench for evt_state_update_engine with a behavioural
// banked state memory (one-cycle read latency).
module tb_evt_state_update_engine;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  evt_state_update_engine_if #(.NEURONS_ADDR_WIDTH(AW), .STATE_DATA_WIDTH(DW)) bus ();

  evt_state_update_engine #(.NEURONS_ADDR_WIDTH(AW), .STATE_DATA_WIDTH(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // State memory model: reads suppressed on a same-bank write in the same cycle
  always @(posedge clk) begin
    if (bus.rd_en_o) begin
      if (bus.wr_en_o && (bus.wr_addr_o[0] == bus.rd_addr_o[0]))
        bus.rd_data_i <= 16'hDEAD;
      else
        bus.rd_data_i <= mem[bus.rd_addr_o];
    end
    if (bus.wr_en_o) mem[bus.wr_addr_o] <= bus.wr_data_o;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] init;
    logic [DW-1:0] weight;
    logic [DW-1:0] thr;
    logic [DW-1:0] rv;
    logic [DW-1:0] leak;
    logic [DW-1:0] exp_wr;
    logic          exp_fire;
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input vec_t v);
    int unsigned waited;
    mem[v.addr]      = v.init;
    bus.threshold_i  = v.thr;
    bus.reset_val_i  = v.rv;
    bus.leak_i       = v.leak;
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_addr_i   = v.addr;
    bus.req_weight_i = v.weight;
    #1;
    waited = 0;
    while (!bus.req_ready_o && waited < 8) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("vec_accept", {31'd0, bus.req_ready_o}, 32'd1);
    chk("vec_rd_en", {31'd0, bus.rd_en_o}, 32'd1);
    chk("vec_rd_addr", {20'd0, bus.rd_addr_o}, {20'd0, v.addr});
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    #1;
    chk("vec_wr_en", {31'd0, bus.wr_en_o}, 32'd1);
    chk("vec_wr_addr", {20'd0, bus.wr_addr_o}, {20'd0, v.addr});
    chk("vec_wr_data", {16'd0, bus.wr_data_o}, {16'd0, v.exp_wr});
    @(negedge clk); #1;
    chk("vec_spike_valid", {31'd0, bus.spike_valid_o}, {31'd0, v.exp_fire});
    if (v.exp_fire) chk("vec_spike_addr", {20'd0, bus.spike_addr_o}, {20'd0, v.addr});
    @(negedge clk); #1;
    chk("vec_idle_busy", {31'd0, bus.busy_o}, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] leak_exp;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    bus.req_valid_i   = 1'b1;
    bus.req_addr_i    = 12'd2;
    bus.req_weight_i  = 16'd1;
    bus.threshold_i   = 16'd200;
    bus.reset_val_i   = 16'd0;
    bus.leak_i        = 16'd0;
    bus.rd_data_i     = '0;
    bus.spike_ready_i = 1'b1;

`ifdef EVT_STATE_LEAK_EN
    leak_exp = 16'd45;
`else
    leak_exp = 16'd55;
`endif
    //          addr    init      weight    thr       rv        leak    exp_wr    fire
    vecs[0] = '{12'd5,  16'd100,  16'd20,   16'd200,  16'd0,    16'd0,  16'd120,  1'b0};
    vecs[1] = '{12'd6,  16'd190,  16'd15,   16'd200,  16'd0,    16'd0,  16'd0,    1'b1};
    vecs[2] = '{12'd9,  16'h7FF0, 16'h0100, 16'h7FFF, 16'h1234, 16'd0,  16'h1234, 1'b1};
    vecs[3] = '{12'd10, 16'hFFFF, 16'h8000, 16'h7FFF, 16'd0,    16'd0,  16'h8000, 1'b0};
    vecs[4] = '{12'd11, 16'd50,   16'd5,    16'd200,  16'd0,    16'd10, leak_exp, 1'b0};
    vecs[5] = '{12'd12, 16'd100,  16'd100,  16'd200,  16'hFFFB, 16'd0,  16'hFFFB, 1'b1};
    vecs[6] = '{12'd13, 16'hFFF6, 16'hFFFB, 16'hFFEC, 16'd7,    16'd0,  16'd7,    1'b1};
    vecs[7] = '{12'd14, 16'hFFE2, 16'd5,    16'hFFEC, 16'd0,    16'd0,  16'hFFE7, 1'b0};

    // Reset with a request already pending
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_rd_en", {31'd0, bus.rd_en_o}, 32'd0);
      chk("rst_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
      chk("rst_spike", {31'd0, bus.spike_valid_o}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready_after", {31'd0, bus.req_ready_o}, 32'd1);
    bus.req_valid_i = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    bus.leak_i = 16'd0;

    // Spike held under back-pressure, no accept while the slot is full
    mem[6] = 16'd190;
    bus.threshold_i = 16'd200;
    bus.reset_val_i = 16'd0;
    bus.spike_ready_i = 1'b0;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_addr_i = 12'd6; bus.req_weight_i = 16'd15;
    #1;
    chk("hold_accept", {31'd0, bus.req_ready_o}, 32'd1);
    @(negedge clk);
    bus.req_addr_i = 12'd3;
    #1;
    chk("hold_wr_data", {16'd0, bus.wr_data_o}, 32'd0);
    chk("hold_ready_firing", {31'd0, bus.req_ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("hold_spike_valid", {31'd0, bus.spike_valid_o}, 32'd1);
      chk("hold_spike_addr", {20'd0, bus.spike_addr_o}, 32'd6);
      chk("hold_ready", {31'd0, bus.req_ready_o}, 32'd0);
      chk("hold_rd_en", {31'd0, bus.rd_en_o}, 32'd0);
    end
    bus.spike_ready_i = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    #1;
    chk("hold_spike_cleared", {31'd0, bus.spike_valid_o}, 32'd0);
    chk("hold_ready_back", {31'd0, bus.req_ready_o}, 32'd1);

    // Same-address back-to-back: second accept stalls one cycle
    mem[4] = 16'd0;
    bus.threshold_i = 16'd1000;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_addr_i = 12'd4; bus.req_weight_i = 16'd10;
    #1;
    chk("stall_first_ready", {31'd0, bus.req_ready_o}, 32'd1);
    @(negedge clk); #1;
    chk("stall_ready_low", {31'd0, bus.req_ready_o}, 32'd0);
    chk("stall_rd_en_low", {31'd0, bus.rd_en_o}, 32'd0);
    chk("stall_wr1_data", {16'd0, bus.wr_data_o}, 32'd10);
    @(negedge clk); #1;
    chk("stall_second_ready", {31'd0, bus.req_ready_o}, 32'd1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    #1;
    chk("stall_wr2_data", {16'd0, bus.wr_data_o}, 32'd20);
    @(negedge clk); #1;
    chk("stall_mem4", {16'd0, mem[4]}, 32'd20);

    // Opposite parity: 4 then 7 accepted on consecutive cycles
    mem[7] = 16'd0;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_addr_i = 12'd4; bus.req_weight_i = 16'd1;
    #1;
    chk("alt_first_ready", {31'd0, bus.req_ready_o}, 32'd1);
    @(negedge clk);
    bus.req_addr_i = 12'd7; bus.req_weight_i = 16'd3;
    #1;
    chk("alt_second_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("alt_wr4_data", {16'd0, bus.wr_data_o}, 32'd21);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    #1;
    chk("alt_wr7_addr", {20'd0, bus.wr_addr_o}, 32'd7);
    chk("alt_wr7_data", {16'd0, bus.wr_data_o}, 32'd3);

    // Reset mid-operation discards the in-flight write
    @(negedge clk);
    mem[8] = 16'd5;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_addr_i = 12'd8; bus.req_weight_i = 16'd1;
    @(posedge clk);
    #2;
    bus.req_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("midrst_no_write", {31'd0, bus.wr_en_o}, 32'd0);
      @(negedge clk);
    end
    chk("midrst_mem8", {16'd0, mem[8]}, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
